// File: rtl/qspi_phase_counter.sv
// qspi_phase_counter: times one QSPI frame phase (command, address, dummy or
// data) in SCK cycles, derived from a bit count and the lane mode.
// Supports hold (SCK stall), abort and a registered one-cycle done pulse.
//
// Optional feature, macro QSPI_PHASE_RELOAD_EN: a start seen while last_cycle
// is high reloads the counter and stays in RUN, so consecutive phases run with
// no idle gap. Without the macro a one-cycle DONE state always separates phases.
module qspi_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] target_bits,
  input  logic [1:0]       lane_mode,
  input  logic             hold,
  input  logic             abort,
  output logic             busy,
  output logic             last_cycle,
  output logic [CNT_W-1:0] cycles_left,
  output logic             count_done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;

  logic [1:0]       lane_shift;
  logic [CNT_W:0]   lane_round;
  logic [CNT_W:0]   cycles_wide;
  logic [CNT_W-1:0] start_cycles;
  logic             start_zero;

  // Bits-to-cycles conversion: ceil(bits / lanes), widened by one bit so the
  // rounding add cannot wrap; the shifted result always fits in CNT_W.
  always_comb begin
    lane_shift = 2'd2;                 // quad, and reserved 11 treated as quad
    lane_round = '0;
    case (lane_mode)
      2'b00:   lane_shift = 2'd0;
      2'b01:   lane_shift = 2'd1;
      default: lane_shift = 2'd2;
    endcase
    lane_round[1:0] = (lane_shift == 2'd0) ? 2'd0 :
                      (lane_shift == 2'd1) ? 2'd1 : 2'd3;
    cycles_wide  = ({1'b0, target_bits} + lane_round) >> lane_shift;
    start_cycles = cycles_wide[CNT_W-1:0];
    start_zero   = (cycles_wide == '0);
  end

  // Outputs decoded from registered state; last_cycle also sees hold so the
  // shift engine knows whether this edge really retires the final cycle.
  assign busy        = (state_q == RUN);
  assign cycles_left = busy ? remaining_q : '0;
  assign last_cycle  = busy && (remaining_q == CNT_W'(1)) && !hold;
  assign count_done  = done_q;

  // Next-state logic: abort beats start and hold; hold beats the decrement.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (start_zero) begin
            done_d = 1'b1;             // zero-length phase: pulse, stay idle
          end else begin
            state_d     = RUN;
            remaining_d = start_cycles;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (last_cycle) begin
          done_d = 1'b1;
`ifdef QSPI_PHASE_RELOAD_EN
          if (start && !start_zero) begin
            remaining_d = start_cycles;  // back-to-back phase, no idle gap
          end else begin
            state_d     = DONE;
            remaining_d = '0;
          end
`else
          state_d     = DONE;
          remaining_d = '0;
`endif
        end else if (!hold) begin
          remaining_d = remaining_q - 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // State, remaining count and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

endmodule
